uart_rx_fifo: RTL

- Receive buffer that sits directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle data-valid pulse and stores it in a DEPTH-entry circular FIFO.
- Presents the oldest byte show-ahead to the bus-side register interface.
- Generates level, watermark, overflow and (optionally) character-timeout status for the interrupt controller.

---
 rtl/uart_rx_fifo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive buffer that sits directly after the UART receiver. Each byte arrives
// on a one-cycle strobe and is stored in a circular register-array FIFO. The
// oldest byte is always visible on rd_data_o (show-ahead). The block also
// reports fill level, a watermark interrupt, a sticky overflow flag and an
// optional character-timeout interrupt.
//
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN
//   defined   -> 16-bit idle counter drives timeout_irq_o
//   undefined -> timeout_irq_o is tied low and timeout_i is ignored
// The port list is the same in both builds.
//
// DEPTH must be a power of two in the range 2..256. The pointers then wrap
// naturally, and level needs one more bit than the pointers.

module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    input  logic          fifo_clr_i,
    input  logic [AW:0]   watermark_i,
    input  logic          ovf_clr_i,
    input  logic [15:0]   timeout_i,
    output logic [AW:0]   level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          wm_irq_o,
    output logic          ovf_o,
    output logic          timeout_irq_o
);

    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic          r_written;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);

    // A flush discards everything in its cycle. A pop needs data. A push into a
    // full FIFO is still accepted if a pop frees the head slot in the same cycle.
    assign w_pop  = rd_en_i && !w_empty && !fifo_clr_i;
    assign w_push = rx_dv_i && !fifo_clr_i && (!w_full || w_pop);
    assign w_drop = rx_dv_i && !fifo_clr_i && w_full && !w_pop;

    // Storage is deliberately not reset. A byte strobed while reset is active
    // is lost because the pointers are held at zero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= rx_byte_i;
        end
    end

    // Pointer and level bookkeeping. A flush has priority over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (fifo_clr_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Tracks whether any byte has been stored since reset. The read port then
    // shows zero after reset without clearing the storage array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_written <= 1'b0;
        end else if (w_push) begin
            r_written <= 1'b1;
        end
    end

    // Sticky overflow flag. A dropped byte beats a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] r_idleCnt;
    logic        r_timeoutIrq;

    // Idle counter. Any FIFO activity or an empty FIFO restarts it, and it
    // saturates instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idleCnt <= '0;
        end else if (fifo_clr_i || w_push || w_pop || w_empty) begin
            r_idleCnt <= '0;
        end else if (r_idleCnt != 16'hFFFF) begin
            r_idleCnt <= r_idleCnt + 16'd1;
        end
    end

    // Timeout flag. It sets timeout_i cycles after the last activity and stays
    // set until a pop or a flush. A new push does not clear it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timeoutIrq <= 1'b0;
        end else if (fifo_clr_i || w_pop) begin
            r_timeoutIrq <= 1'b0;
        end else if ((timeout_i != 16'd0) && (r_idleCnt == timeout_i - 16'd1)) begin
            r_timeoutIrq <= 1'b1;
        end
    end

    assign timeout_irq_o = r_timeoutIrq;
`else
    logic w_unusedTimeout;

    assign w_unusedTimeout = ^timeout_i;
    assign timeout_irq_o   = 1'b0;
`endif

    // Every status output comes from registered state only, so there is no
    // combinational path from the strobes to the interrupt controller.
    assign rd_data_o = r_written ? r_mem[r_rdPtr] : 8'h00;
    assign level_o   = r_level;
    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign ovf_o     = r_ovf;
    assign wm_irq_o  = (watermark_i != '0) && (r_level >= watermark_i);

endmodule
